// File: rtl/usb_cmd_engine.sv
// Host-command engine: executes {addr,data} pairs from the EP2 OUT buffer against a byte-wide
// wishbone master and a local register bank, batching read responses into one IN commit.
module usb_cmd_engine #(
  parameter int                    NUM_REGS   = 4,
  parameter logic [NUM_REGS*8-1:0] REG_INIT   = 32'h000200F3,
  parameter int                    RD_LAT     = 4,
  parameter int                    WB_TIMEOUT = 1023,
  parameter int                    MAX_RESP   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  buf_out_hasdata,
  input  logic [9:0]            buf_out_len,
  output logic [8:0]            buf_out_addr,
  input  logic [7:0]            buf_out_q,
  output logic                  buf_out_arm,
  input  logic                  buf_out_arm_ack,
  output logic [2:0]            wb_adr_o,
  output logic [7:0]            wb_dat_o,
  output logic                  wb_we_o,
  output logic                  wb_stb_o,
  input  logic [7:0]            wb_dat_i,
  input  logic                  wb_ack_i,
  output logic [8:0]            buf_in_addr,
  output logic [7:0]            buf_in_data,
  output logic                  buf_in_wren,
  input  logic                  buf_in_ready,
  output logic                  buf_in_commit,
  output logic [9:0]            buf_in_commit_len,
  input  logic                  buf_in_commit_ack,
  output logic [NUM_REGS*8-1:0] regs_o,
  output logic [7:0]            err_cnt,
  output logic                  busy
);

  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam int TO_W  = $clog2(WB_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, FETCH_A, FETCH_D, EXEC, WB_WAIT, NEXT, RELEASE, COMMIT} state_t;
  typedef enum logic [2:0] {OP_WB_WR, OP_WB_RD, OP_REG_WR, OP_REG_RD, OP_BAD} op_t;

  state_t                state;
  op_t                   op;
  logic [9:0]            ptr;
  logic [9:0]            resp_cnt;
  logic [LAT_W-1:0]      lat_cnt;
  logic [TO_W-1:0]       wb_cnt;
  logic [7:0]            cmd_a;
  logic [7:0]            cmd_d;
  logic                  arm_ack_q;
  logic [NUM_REGS*8-1:0] regs_q;
  logic [7:0]            rd_val;
  logic                  wb_timeout;
  logic                  wb_done;
  logic                  pair_more;
  logic                  resp_full;
  logic                  resp_req;
  logic [7:0]            resp_val;
  logic [1:0]            err_inc;
  logic [8:0]            err_sum;

  assign regs_o     = regs_q;
  assign busy       = (state != IDLE);
  assign wb_timeout = (wb_cnt == TO_W'(WB_TIMEOUT - 1));
  assign wb_done    = wb_ack_i || wb_timeout;
  assign pair_more  = ({1'b0, ptr} + 11'd1) < {1'b0, buf_out_len};
  assign resp_full  = (resp_cnt == 10'(MAX_RESP));
  assign err_sum    = {1'b0, err_cnt} + 9'(err_inc);

  always_comb begin
    op = OP_BAD;
    if (cmd_a[7:3] == 5'b00000)
      op = OP_WB_WR;
    else if (cmd_a[7:3] == 5'b10000)
      op = OP_WB_RD;
    else if (cmd_a[7:4] == 4'h1 && 32'(cmd_a[3:0]) < NUM_REGS)
      op = OP_REG_WR;
    else if (cmd_a[7:4] == 4'h9 && 32'(cmd_a[3:0]) < NUM_REGS)
      op = OP_REG_RD;
  end

  always_comb begin
    rd_val = 8'h00;
    for (int i = 0; i < NUM_REGS; i++)
      if (cmd_a[3:0] == 4'(i)) rd_val = regs_q[8*i +: 8];
  end

  // A wishbone read that times out still answers, with 0xEE in place of the missing data
  always_comb begin
    resp_req = (state == EXEC && op == OP_REG_RD) || (state == WB_WAIT && wb_done && !wb_we_o);
    resp_val = (state == EXEC) ? rd_val : (wb_ack_i ? wb_dat_i : 8'hEE);
  end

  always_comb begin
    err_inc = 2'd0;
    case (state)
      IDLE:    if (buf_out_hasdata && buf_out_len == 10'd1) err_inc = 2'd1;
      EXEC:    if (op == OP_BAD) err_inc = 2'd1;
      WB_WAIT: if (wb_timeout && !wb_ack_i) err_inc = 2'd1;
      NEXT:    if (!pair_more && ptr != buf_out_len) err_inc = 2'd1;
      default: err_inc = 2'd0;
    endcase
    if (resp_req && resp_full) err_inc = err_inc + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      ptr               <= '0;
      resp_cnt          <= '0;
      lat_cnt           <= '0;
      wb_cnt            <= '0;
      cmd_a             <= '0;
      cmd_d             <= '0;
      arm_ack_q         <= 1'b0;
      regs_q            <= REG_INIT;
      buf_out_addr      <= '0;
      buf_out_arm       <= 1'b0;
      wb_adr_o          <= '0;
      wb_dat_o          <= '0;
      wb_we_o           <= 1'b0;
      wb_stb_o          <= 1'b0;
      buf_in_addr       <= '0;
      buf_in_data       <= '0;
      buf_in_wren       <= 1'b0;
      buf_in_commit     <= 1'b0;
      buf_in_commit_len <= '0;
      err_cnt           <= '0;
    end else begin
      buf_in_wren <= 1'b0;
      arm_ack_q   <= buf_out_arm_ack;
      err_cnt     <= err_sum[8] ? 8'hFF : err_sum[7:0];
      if (resp_req && !resp_full) begin
        buf_in_wren <= 1'b1;
        buf_in_addr <= resp_cnt[8:0];
        buf_in_data <= resp_val;
        resp_cnt    <= resp_cnt + 10'd1;
      end
      case (state)
        IDLE: begin
          ptr      <= '0;
          resp_cnt <= '0;
          if (buf_out_hasdata) begin
            if (buf_out_len < 10'd2) begin
              state <= RELEASE;
            end else begin
              buf_out_addr <= '0;
              lat_cnt      <= '0;
              state        <= FETCH_A;
            end
          end
        end
        FETCH_A: begin
          if (lat_cnt == LAT_W'(RD_LAT - 1)) begin
            cmd_a        <= buf_out_q;
            ptr          <= ptr + 10'd1;
            buf_out_addr <= 9'(ptr + 10'd1);
            lat_cnt      <= '0;
            state        <= FETCH_D;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        FETCH_D: begin
          if (lat_cnt == LAT_W'(RD_LAT - 1)) begin
            cmd_d   <= buf_out_q;
            ptr     <= ptr + 10'd1;
            lat_cnt <= '0;
            state   <= EXEC;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        EXEC: begin
          state <= NEXT;
          if (op == OP_WB_WR || op == OP_WB_RD) begin
            wb_adr_o <= cmd_a[2:0];
            wb_dat_o <= cmd_d;
            wb_we_o  <= (op == OP_WB_WR);
            wb_stb_o <= 1'b1;
            wb_cnt   <= '0;
            state    <= WB_WAIT;
          end
          if (op == OP_REG_WR)
            for (int i = 0; i < NUM_REGS; i++)
              if (cmd_a[3:0] == 4'(i)) regs_q[8*i +: 8] <= cmd_d;
        end
        WB_WAIT: begin
          if (wb_done) begin
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            state    <= NEXT;
          end else begin
            wb_cnt <= wb_cnt + 1'b1;
          end
        end
        NEXT: begin
          if (pair_more) begin
            buf_out_addr <= ptr[8:0];
            lat_cnt      <= '0;
            state        <= FETCH_A;
          end else begin
            state <= RELEASE;
          end
        end
        // Hold arm until the acknowledge has been seen high and then low again
        RELEASE: begin
          if (arm_ack_q && !buf_out_arm_ack) begin
            buf_out_arm <= 1'b0;
            state       <= (resp_cnt == 10'd0) ? IDLE : COMMIT;
          end else begin
            buf_out_arm <= 1'b1;
          end
        end
        COMMIT: begin
          if (buf_in_commit) begin
            if (buf_in_commit_ack) begin
              buf_in_commit <= 1'b0;
              state         <= IDLE;
            end
          end else if (buf_in_ready) begin
            buf_in_commit     <= 1'b1;
            buf_in_commit_len <= resp_cnt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_cmd_engine.sv
// Directed testbench for usb_cmd_engine with simple models of the OUT buffer, wishbone slave
// and IN buffer; expected values are hand-computed constants.
module tb_usb_cmd_engine;

  localparam int RD_LAT = 4;

  logic        clk;
  logic        reset;
  logic        buf_out_hasdata;
  logic [9:0]  buf_out_len;
  logic [8:0]  buf_out_addr;
  logic [7:0]  buf_out_q;
  logic        buf_out_arm;
  logic        buf_out_arm_ack;
  logic [2:0]  wb_adr_o;
  logic [7:0]  wb_dat_o;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic [7:0]  wb_dat_i;
  logic        wb_ack_i;
  logic [8:0]  buf_in_addr;
  logic [7:0]  buf_in_data;
  logic        buf_in_wren;
  logic        buf_in_ready;
  logic        buf_in_commit;
  logic [9:0]  buf_in_commit_len;
  logic        buf_in_commit_ack;
  logic [31:0] regs_o;
  logic [7:0]  err_cnt;
  logic        busy;

  usb_cmd_engine dut (
    .clk(clk), .reset(reset),
    .buf_out_hasdata(buf_out_hasdata), .buf_out_len(buf_out_len),
    .buf_out_addr(buf_out_addr), .buf_out_q(buf_out_q),
    .buf_out_arm(buf_out_arm), .buf_out_arm_ack(buf_out_arm_ack),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren),
    .buf_in_ready(buf_in_ready), .buf_in_commit(buf_in_commit),
    .buf_in_commit_len(buf_in_commit_len), .buf_in_commit_ack(buf_in_commit_ack),
    .regs_o(regs_o), .err_cnt(err_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // OUT buffer: data appears RD_LAT cycles after the address changes
  logic [7:0] out_mem [512];
  logic [8:0] addr_pipe [RD_LAT-1];
  assign buf_out_q = out_mem[addr_pipe[RD_LAT-2]];
  always @(posedge clk) begin
    addr_pipe[0] <= buf_out_addr;
    for (int i = 1; i < RD_LAT - 1; i++) addr_pipe[i] <= addr_pipe[i-1];
  end

  int arm_cnt;
  assign buf_out_arm_ack = (arm_cnt == 2 || arm_cnt == 3);
  always @(posedge clk) arm_cnt <= buf_out_arm ? arm_cnt + 1 : 0;

  int stb_cnt;
  int ack_delay;
  assign wb_ack_i = wb_stb_o && (stb_cnt == ack_delay);
  always @(posedge clk) stb_cnt <= (wb_stb_o && !wb_ack_i) ? stb_cnt + 1 : 0;

  always @(posedge clk) buf_in_commit_ack <= buf_in_commit && !buf_in_commit_ack;

  // Monitors
  logic [2:0] log_adr [16];
  logic [7:0] log_dat [16];
  logic       log_we  [16];
  logic [7:0] in_mem  [512];
  int wb_n, stb_cycles, in_wr_n, commit_n, arm_n;
  logic [9:0] last_commit_len;
  logic arm_q;

  always @(posedge clk) begin
    arm_q <= buf_out_arm;
    if (buf_out_arm && !arm_q) arm_n <= arm_n + 1;
    if (wb_stb_o) stb_cycles <= stb_cycles + 1;
    if (wb_stb_o && wb_ack_i) begin
      log_adr[wb_n % 16] <= wb_adr_o;
      log_dat[wb_n % 16] <= wb_dat_o;
      log_we[wb_n % 16]  <= wb_we_o;
      wb_n <= wb_n + 1;
    end
    if (buf_in_wren) begin
      in_mem[buf_in_addr] <= buf_in_data;
      in_wr_n <= in_wr_n + 1;
    end
    if (buf_in_commit && buf_in_commit_ack) begin
      commit_n <= commit_n + 1;
      last_commit_len <= buf_in_commit_len;
    end
  end

  int tests_run;
  int tests_failed;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one packet, release it when armed, and wait for the engine to go idle
  task automatic applyStimulus(input int len, input int max_cycles);
    logic seen;
    buf_out_len = 10'(len);
    buf_out_hasdata = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge clk);
      seen = buf_out_arm;
    end
    checkOutput("arm_seen", 32'(seen), 32'd1);
    buf_out_hasdata = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge clk);
      seen = !busy;
    end
    checkOutput("idle_seen", 32'(seen), 32'd1);
  endtask

  int arm0, wb0, commit0, in0, stb0;

  task automatic snapshot();
    arm0 = arm_n; wb0 = wb_n; commit0 = commit_n; in0 = in_wr_n; stb0 = stb_cycles;
  endtask

  initial begin
    logic seen;
    tests_run = 0; tests_failed = 0;
    wb_n = 0; stb_cycles = 0; in_wr_n = 0; commit_n = 0; arm_n = 0;
    reset = 1'b1; buf_out_hasdata = 1'b0; buf_out_len = '0;
    wb_dat_i = 8'h00; buf_in_ready = 1'b1; ack_delay = 3;
    for (int i = 0; i < 512; i++) out_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    checkOutput("rst_regs", regs_o, 32'h000200F3);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_stb", 32'(wb_stb_o), 32'd0);
    checkOutput("rst_err", 32'(err_cnt), 32'd0);
    checkOutput("rst_arm", 32'(buf_out_arm), 32'd0);
    checkOutput("rst_commit", 32'(buf_in_commit), 32'd0);

    // Readback reg0, wishbone read adr4, readback reg1 -> one commit of 3 bytes
    snapshot();
    out_mem[0] = 8'h90; out_mem[1] = 8'h00; out_mem[2] = 8'h84;
    out_mem[3] = 8'h00; out_mem[4] = 8'h91; out_mem[5] = 8'h00;
    wb_dat_i = 8'h5A; ack_delay = 3;
    applyStimulus(6, 2000);
    checkOutput("c_in0", 32'(in_mem[0]), 32'hF3);
    checkOutput("c_in1", 32'(in_mem[1]), 32'h5A);
    checkOutput("c_in2", 32'(in_mem[2]), 32'h00);
    checkOutput("c_commits", 32'(commit_n - commit0), 32'd1);
    checkOutput("c_len", 32'(last_commit_len), 32'd3);
    checkOutput("c_wb_adr", 32'(log_adr[wb0 % 16]), 32'd4);

    // Local register writes only
    snapshot();
    out_mem[0] = 8'h10; out_mem[1] = 8'hA5; out_mem[2] = 8'h11; out_mem[3] = 8'h3C;
    applyStimulus(4, 2000);
    checkOutput("a_regs", regs_o, 32'h00023CA5);
    checkOutput("a_wb", 32'(wb_n - wb0), 32'd0);
    checkOutput("a_arms", 32'(arm_n - arm0), 32'd1);
    checkOutput("a_commits", 32'(commit_n - commit0), 32'd0);

    // Wishbone write then read
    snapshot();
    out_mem[0] = 8'h02; out_mem[1] = 8'h80; out_mem[2] = 8'h84; out_mem[3] = 8'h00;
    wb_dat_i = 8'h41;
    applyStimulus(4, 2000);
    checkOutput("b_wb", 32'(wb_n - wb0), 32'd2);
    checkOutput("b_wr_adr", 32'(log_adr[wb0 % 16]), 32'd2);
    checkOutput("b_wr_dat", 32'(log_dat[wb0 % 16]), 32'h80);
    checkOutput("b_wr_we", 32'(log_we[wb0 % 16]), 32'd1);
    checkOutput("b_rd_adr", 32'(log_adr[(wb0 + 1) % 16]), 32'd4);
    checkOutput("b_rd_we", 32'(log_we[(wb0 + 1) % 16]), 32'd0);
    checkOutput("b_in0", 32'(in_mem[0]), 32'h41);
    checkOutput("b_len", 32'(last_commit_len), 32'd1);

    // Read never acknowledged
    snapshot();
    out_mem[0] = 8'h80; out_mem[1] = 8'h00;
    ack_delay = 100000;
    applyStimulus(2, 3000);
    checkOutput("to_stb_cycles", 32'(stb_cycles - stb0), 32'd1023);
    checkOutput("to_in0", 32'(in_mem[0]), 32'hEE);
    checkOutput("to_err", 32'(err_cnt), 32'd1);
    checkOutput("to_len", 32'(last_commit_len), 32'd1);
    ack_delay = 3;

    // Odd length: trailing byte ignored
    snapshot();
    out_mem[0] = 8'h12; out_mem[1] = 8'h77; out_mem[2] = 8'h13; out_mem[3] = 8'h66; out_mem[4] = 8'h99;
    applyStimulus(5, 2000);
    checkOutput("odd_regs", regs_o, 32'h66773CA5);
    checkOutput("odd_err", 32'(err_cnt), 32'd2);
    checkOutput("odd_commits", 32'(commit_n - commit0), 32'd0);

    out_mem[0] = 8'h40; out_mem[1] = 8'h00;
    applyStimulus(2, 2000);
    checkOutput("bad_err", 32'(err_cnt), 32'd3);

    snapshot();
    out_mem[0] = 8'h90;
    applyStimulus(1, 2000);
    checkOutput("len1_err", 32'(err_cnt), 32'd4);
    checkOutput("len1_in", 32'(in_wr_n - in0), 32'd0);
    checkOutput("len1_arms", 32'(arm_n - arm0), 32'd1);

    snapshot();
    applyStimulus(0, 2000);
    checkOutput("len0_err", 32'(err_cnt), 32'd4);
    checkOutput("len0_arms", 32'(arm_n - arm0), 32'd1);

    // 65 readbacks: the 65th is dropped
    snapshot();
    for (int i = 0; i < 65; i++) begin
      out_mem[2*i] = 8'h90; out_mem[2*i+1] = 8'h00;
    end
    applyStimulus(130, 3000);
    checkOutput("max_in", 32'(in_wr_n - in0), 32'd64);
    checkOutput("max_len", 32'(last_commit_len), 32'd64);
    checkOutput("max_byte63", 32'(in_mem[63]), 32'hA5);
    checkOutput("max_err", 32'(err_cnt), 32'd5);

    // 256 unknown commands push err_cnt past 255
    for (int i = 0; i < 256; i++) begin
      out_mem[2*i] = 8'h40; out_mem[2*i+1] = 8'h00;
    end
    applyStimulus(512, 6000);
    checkOutput("sat_err", 32'(err_cnt), 32'hFF);
    applyStimulus(2, 2000);
    checkOutput("sat_hold", 32'(err_cnt), 32'hFF);

    // Reset while a wishbone read is outstanding
    snapshot();
    out_mem[0] = 8'h80; out_mem[1] = 8'h00;
    ack_delay = 100000;
    buf_out_len = 10'd2;
    buf_out_hasdata = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = wb_stb_o;
    end
    checkOutput("mid_stb_seen", 32'(seen), 32'd1);
    repeat (5) @(negedge clk);
    buf_out_hasdata = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mid_regs", regs_o, 32'h000200F3);
    checkOutput("mid_stb", 32'(wb_stb_o), 32'd0);
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_err", 32'(err_cnt), 32'd0);
    repeat (20) @(negedge clk);
    checkOutput("mid_commits", 32'(commit_n - commit0), 32'd0);
    checkOutput("mid_arms", 32'(arm_n - arm0), 32'd0);
    checkOutput("mid_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
